// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and sizing for the program loader
package loader_pkg;

   localparam int unsigned MAX_WORDS = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

endpackage

// File: rtl/loader_wport.sv
// rtl/loader_wport.sv - registered RAM write port, strobe one cycle after the accepted byte
module loader_wport #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              we_q, we_d;

   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      we_d   = wr_en;
      if (wr_en) begin
         addr_d = wr_addr;
         data_d = wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q <= '0;
         data_q <= '0;
         we_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         we_q   <= we_d;
      end
   end

   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign mem_we   = we_q;

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length/data/checksum byte stream into program RAM, holding the CPU meanwhile
module prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W = $clog2(MAX_WORDS),
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_we,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   words_q, words_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              pvalid_q, pvalid_d;
   logic              xfer, wr_en, len_bad;

   assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign xfer     = in_valid && in_ready;
   assign len_bad  = (in_data == '0) || (32'(in_data) > (32'd1 << ADDR_W));

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      words_d  = words_q;
      sum_d    = sum_q;
      err_d    = err_q;
      pvalid_d = pvalid_q;
      done_d   = 1'b0;
      wr_en    = 1'b0;
      case (state_q)
         ST_IDLE, ST_ERR: begin
            if (start) begin
               state_d  = ST_LEN;
               err_d    = 1'b0;
               words_d  = '0;
               sum_d    = '0;
               pvalid_d = 1'b0;
            end
         end
         ST_LEN: begin
            if (xfer) begin
               if (len_bad) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
               end else begin
                  len_d   = in_data[ADDR_W:0];
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (xfer) begin
               wr_en   = 1'b1;
               sum_d   = sum_q + in_data;
               words_d = words_q + 1'b1;
               if (words_d == len_q) state_d = ST_CSUM;
            end
         end
         ST_CSUM: begin
            if (xfer) begin
               if (in_data == sum_q) begin
                  done_d   = 1'b1;
                  pvalid_d = 1'b1;
                  state_d  = ST_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         len_q    <= '0;
         words_q  <= '0;
         sum_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         pvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         words_q  <= words_d;
         sum_q    <= sum_d;
         err_q    <= err_d;
         done_q   <= done_d;
         pvalid_q <= pvalid_d;
      end
   end

   // Address is the pre-increment count, so word k lands at address k.
   loader_wport #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wport (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_addr (words_q[ADDR_W-1:0]),
      .wr_data (in_data),
      .mem_addr(mem_addr),
      .mem_data(mem_data),
      .mem_we  (mem_we)
   );

   assign busy         = in_ready;
   assign cpu_hold     = busy || !pvalid_q;
   assign done         = done_q;
   assign error        = err_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - table-driven sessions with a write scoreboard, plus mid-session reset
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst, start, in_valid;
   logic [7:0] in_data;
   logic       in_ready, mem_we, cpu_hold, busy, done, error;
   logic [3:0] mem_addr;
   logic [7:0] mem_data;
   logic [4:0] words_loaded;

   prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          len;
      logic [159:0] raw;
      int          gap;
      bit          mid_start;
      bit          exp_done;
      bit          exp_err;
      int          exp_words;
      int          exp_run;
   } vec_t;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_t;

   vec_t vecs [7];
   wr_t  exp_q [$];
   wr_t  got;
   int   cmp_cnt = 0, bad_cnt = 0;
   int   done_cnt = 0, we_cnt = 0, run = 0, max_run = 0, pushed = 0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (mem_we) begin
         we_cnt++;
         run++;
         if (run > max_run) max_run = run;
         cmp_cnt++;
         if (exp_q.size() == 0) begin
            bad_cnt++;
            $display("FAIL unexpected_write: got addr=%0h data=%0h, expected no write", mem_addr, mem_data);
         end else begin
            got = exp_q.pop_front();
            if (got.addr !== mem_addr || got.data !== mem_data) begin
               bad_cnt++;
               $display("FAIL write: got %0h@%0h, expected %0h@%0h", mem_data, mem_addr, got.data, got.addr);
            end
         end
      end else begin
         run = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] byte_at(input vec_t v, input int j);
      return 8'(v.raw >> (8 * (v.len - 1 - j)));
   endfunction

   task automatic send(input logic [7:0] b);
      int k = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) begin
         cmp_cnt++;
         bad_cnt++;
         $display("FAIL send_timeout: in_ready stayed 0 for byte %0h, expected 1", b);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic run_vec(input int idx);
      vec_t v = vecs[idx];
      int   n;
      done_cnt = 0; we_cnt = 0; run = 0; max_run = 0; pushed = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = int'(byte_at(v, 0));
      if (n >= 1 && n <= 16) begin
         for (int j = 1; j <= n; j++) begin
            exp_q.push_back('{addr: 4'(j - 1), data: byte_at(v, j)});
            pushed++;
         end
      end
      for (int j = 0; j < v.len; j++) begin
         send(byte_at(v, j));
         if (j < v.len - 1 && v.gap > 0) begin
            in_valid = 1'b0;
            if (j == 1 && v.mid_start) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (v.gap - 1) @(negedge clk);
         end
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_done_pulses", idx), done_cnt, v.exp_done ? 1 : 0);
      chk($sformatf("v%0d_error", idx), error, v.exp_err);
      chk($sformatf("v%0d_cpu_hold", idx), cpu_hold, !v.exp_done);
      chk($sformatf("v%0d_words_loaded", idx), words_loaded, v.exp_words);
      chk($sformatf("v%0d_busy", idx), busy, 0);
      chk($sformatf("v%0d_write_count", idx), we_cnt, pushed);
      chk($sformatf("v%0d_write_burst", idx), max_run, v.exp_run);
      chk($sformatf("v%0d_pending_writes", idx), exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1);
   end

   initial begin
      logic [159:0] r;
      vecs[0] = '{len: 5, raw: 160'({8'h03, 8'h11, 8'h22, 8'h33, 8'h66}), gap: 0, mid_start: 0,
                  exp_done: 1, exp_err: 0, exp_words: 3, exp_run: 3};
      vecs[1] = '{len: 1, raw: 160'(8'h00), gap: 0, mid_start: 0,
                  exp_done: 0, exp_err: 1, exp_words: 0, exp_run: 0};
      vecs[2] = '{len: 4, raw: 160'({8'h02, 8'h80, 8'h90, 8'h11}), gap: 0, mid_start: 0,
                  exp_done: 0, exp_err: 1, exp_words: 2, exp_run: 2};
      r = 160'(8'h10);
      for (int k = 1; k <= 16; k++) r = {r[151:0], 8'(k)};
      r = {r[151:0], 8'h88};
      vecs[3] = '{len: 18, raw: r, gap: 0, mid_start: 0,
                  exp_done: 1, exp_err: 0, exp_words: 16, exp_run: 16};
      vecs[4] = '{len: 1, raw: 160'(8'h11), gap: 0, mid_start: 0,
                  exp_done: 0, exp_err: 1, exp_words: 0, exp_run: 0};
      vecs[5] = '{len: 4, raw: 160'({8'h02, 8'hFF, 8'h02, 8'h01}), gap: 0, mid_start: 0,
                  exp_done: 1, exp_err: 0, exp_words: 2, exp_run: 2};
      vecs[6] = '{len: 5, raw: 160'({8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h31}), gap: 1, mid_start: 1,
                  exp_done: 1, exp_err: 0, exp_words: 3, exp_run: 1};

      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_data", mem_data, 0);
      chk("rst_words", words_loaded, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(i);

      // Reset lands after the second data byte's strobe has been seen.
      we_cnt = 0;
      exp_q.push_back('{addr: 4'h0, data: 8'h01});
      exp_q.push_back('{addr: 4'h1, data: 8'h02});
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send(8'h05);
      send(8'h01);
      send(8'h02);
      in_data = 8'h03;
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_mem_we", mem_we, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_cpu_hold", cpu_hold, 1);
      chk("mid_rst_words", words_loaded, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      chk("mid_rst_write_count", we_cnt, 2);
      chk("mid_rst_pending", exp_q.size(), 0);
      chk("mid_rst_idle_hold", cpu_hold, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
      $finish;
   end

endmodule
